// File: rtl/switch_bounce_gen_if.sv
// Level/bounce handshake bundle between a clean-level source and the bounce emulator.
interface switch_bounce_gen_if;
  logic clean;
  logic bounce_en;
  logic bouncy;
  logic busy;

  modport master (output clean, output bounce_en, input bouncy, input busy);
  modport slave  (input clean, input bounce_en, output bouncy, output busy);
endinterface

// File: rtl/switch_bounce_gen.sv
// Switch-contact bounce emulator: re-emits a clean level with a burst of
// LFSR-timed glitch toggles before settling on the new level.
module switch_bounce_gen #(
  parameter int unsigned BounceCount = 2,
  parameter int unsigned SegBits     = 10,
  parameter logic [15:0] LfsrSeed    = 16'hACE1,
  parameter logic        ResetLevel  = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  switch_bounce_gen_if.slave  bus
);

  localparam int unsigned Toggles = 2 * BounceCount;
  localparam int unsigned CntW    = (Toggles > 1) ? $clog2(Toggles + 1) : 1;
  localparam int unsigned TimerW  = SegBits + 1;
  localparam logic [CntW-1:0] TogglesInit = CntW'(Toggles);
  localparam bit NoBounce = (BounceCount == 0);

  typedef enum logic {StIdle, StBounce} state_e;

  state_e              state_q, state_d;
  logic                bouncy_q, bouncy_d;
  logic                target_q, target_d;
  logic                busy_q, busy_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [CntW-1:0]     toggles_q, toggles_d;
  logic [TimerW-1:0]   timer_q, timer_d;

  logic                lfsr_fb;
  logic [15:0]         lfsr_next;
  logic [TimerW-1:0]   seg_len;

  // x^16 + x^14 + x^13 + x^11 + 1, shifted left with feedback into bit 0
  assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign lfsr_next = {lfsr_q[14:0], lfsr_fb};
  assign seg_len   = TimerW'(lfsr_q[SegBits-1:0]) + TimerW'(1);

  always_comb begin
    state_d   = state_q;
    bouncy_d  = bouncy_q;
    target_d  = target_q;
    busy_d    = busy_q;
    lfsr_d    = lfsr_q;
    toggles_d = toggles_q;
    timer_d   = timer_q;

    if (bus.clean != target_q) begin
      // A new level always wins, including over a coincident timer expiry
      bouncy_d = bus.clean;
      target_d = bus.clean;
      if (!bus.bounce_en || NoBounce) begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end else begin
        state_d   = StBounce;
        busy_d    = 1'b1;
        toggles_d = TogglesInit;
        timer_d   = seg_len;
        lfsr_d    = lfsr_next;
      end
    end else if (state_q == StBounce) begin
      if (!bus.bounce_en) begin
        bouncy_d = target_q;
        state_d  = StIdle;
        busy_d   = 1'b0;
      end else if (timer_q == TimerW'(1)) begin
        bouncy_d  = ~bouncy_q;
        toggles_d = toggles_q - CntW'(1);
        if (toggles_q == CntW'(1)) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else begin
          timer_d = seg_len;
          lfsr_d  = lfsr_next;
        end
      end else begin
        timer_d = timer_q - TimerW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      bouncy_q  <= ResetLevel;
      target_q  <= ResetLevel;
      busy_q    <= 1'b0;
      lfsr_q    <= LfsrSeed;
      toggles_q <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      bouncy_q  <= bouncy_d;
      target_q  <= target_d;
      busy_q    <= busy_d;
      lfsr_q    <= lfsr_d;
      toggles_q <= toggles_d;
      timer_q   <= timer_d;
    end
  end

  assign bus.bouncy = bouncy_q;
  assign bus.busy   = busy_q;

endmodule
